// File: rtl/imsic_msi_decoder_pkg.sv
// Shared types and helpers for the IMSIC MSI decoder: the queued entry format,
// the register-page constants and the page-to-(hart, file) decode function.
package imsic_pkg;

  localparam int unsigned MsiHartW  = 16;
  localparam int unsigned MsiFileW  = 8;
  localparam int unsigned MsiIpnumW = 16;

  localparam int unsigned ImsicPageShift = 12;
  localparam logic [11:0] SetipnumLeOff  = 12'h000;
  localparam logic [11:0] SetipnumBeOff  = 12'h004;

  // Field widths are fixed at their maximum here; the top level narrows them
  // to the port widths that its parameters imply.
  typedef struct packed {
    logic [MsiHartW-1:0]  hart;
    logic [MsiFileW-1:0]  file;
    logic [MsiIpnumW-1:0] ipnum;
  } msi_entry_t;

  typedef struct packed {
    logic                hit;
    logic [MsiHartW-1:0] hart;
    logic [MsiFileW-1:0] file;
  } page_dec_t;

  // M window wins if the two windows overlap. nr_sfiles is a parameter at
  // every call site, so the divide and modulo reduce to constant logic.
  function automatic page_dec_t imsic_decode_page(input logic [31:0] m_page,
                                                  input logic [31:0] s_page,
                                                  input int unsigned nr_harts,
                                                  input int unsigned nr_sfiles);
    page_dec_t r;
    r = '0;
    if (m_page < nr_harts) begin
      r.hit  = 1'b1;
      r.hart = MsiHartW'(m_page);
    end else if (s_page < nr_harts * nr_sfiles) begin
      r.hit  = 1'b1;
      r.hart = MsiHartW'(s_page / nr_sfiles);
      r.file = MsiFileW'((s_page % nr_sfiles) + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Synchronous FIFO of decoded MSI entries. Pointers wrap modulo Depth; an
// occupancy count one bit wider than the pointers separates full from empty.
// The head payload reads as zero while empty so idle outputs stay clean.
module imsic_msi_fifo
  import imsic_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic       i_clk,
  input  logic       ni_rst,
  input  logic       i_push,
  input  msi_entry_t i_data,
  input  logic       i_pop,
  output msi_entry_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] CntFull = (PtrW + 1)'(Depth);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  msi_entry_t      mem_q [Depth];
  logic            do_push, do_pop;

  assign o_full  = (cnt_q == CntFull);
  assign o_empty = (cnt_q == '0);
  assign do_push = i_push && !o_full;
  assign do_pop  = i_pop && !o_empty;
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; push and pop together leave the count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage; not reset, since the empty gate hides stale entries.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

endmodule

// File: rtl/imsic_msi_decoder.sv
// IMSIC MSI decoder: decodes M and S/VS interrupt-file page writes into
// (hart, file, identity) triples, queues them and issues them with AXI-style
// valid/ready. Requests that fail decode are accepted and counted as drops.
// Build option: IMSIC_BE_SETIPNUM_EN enables the byte-swapped SETEIPNUM_BE
// register at page offset 0x004; without it that offset is dropped.
module imsic_msi_decoder
  import imsic_pkg::*;
#(
  parameter int unsigned          NrHarts     = 4,
  parameter int unsigned          NrInptFiles = 3,
  parameter int unsigned          NrSources   = 64,
  parameter int unsigned          AddrW       = 32,
  parameter logic [AddrW-1:0]     MBase       = 32'h2400_0000,
  parameter logic [AddrW-1:0]     SBase       = 32'h2800_0000,
  parameter int unsigned          FifoDepth   = 4,
  parameter int unsigned          DropCntW    = 16,
  localparam int unsigned         HartW       = (NrHarts > 1) ? $clog2(NrHarts) : 1,
  localparam int unsigned         FileW       = $clog2(NrInptFiles),
  localparam int unsigned         IpnumW      = $clog2(NrSources)
) (
  input  logic                i_clk,
  input  logic                ni_rst,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [AddrW-1:0]    i_req_addr,
  input  logic [31:0]         i_req_data,
  output logic                o_wr_valid,
  input  logic                i_wr_ready,
  output logic [HartW-1:0]    o_wr_hart,
  output logic [FileW-1:0]    o_wr_file,
  output logic [IpnumW-1:0]   o_wr_ipnum,
  output logic                o_drop,
  output logic [DropCntW-1:0] o_drop_cnt
);

  localparam logic [31:0] MaxId = 32'(NrSources - 1);

  logic [AddrW-1:0]    m_off, s_off;
  logic [31:0]         m_page, s_page;
  page_dec_t           dec;
  logic [31:0]         id_sel;
  logic                off_ok, id_ok, accept, push, bad;
  logic                fifo_full, fifo_empty;
  msi_entry_t          push_entry, pop_entry;
  logic                drop_q, drop_d;
  logic [DropCntW-1:0] drop_cnt_q, drop_cnt_d;
  logic                unused_entry_bits;

  // Page number inside each window; an address below a base wraps to a huge page and misses.
  always_comb begin
    m_off  = i_req_addr - MBase;
    s_off  = i_req_addr - SBase;
    m_page = 32'(m_off >> ImsicPageShift);
    s_page = 32'(s_off >> ImsicPageShift);
    dec    = imsic_decode_page(m_page, s_page, NrHarts, NrInptFiles - 1);
  end

  // Register-offset select and identity extraction; the full 32-bit value is range checked.
  always_comb begin
    off_ok = 1'b0;
    id_sel = i_req_data;
    if (i_req_addr[11:0] == SetipnumLeOff) begin
      off_ok = 1'b1;
`ifdef IMSIC_BE_SETIPNUM_EN
    end else if (i_req_addr[11:0] == SetipnumBeOff) begin
      off_ok = 1'b1;
      id_sel = {i_req_data[7:0], i_req_data[15:8], i_req_data[23:16], i_req_data[31:24]};
`endif
    end
    id_ok = (id_sel != 32'd0) && (id_sel <= MaxId);
  end

  assign o_req_ready = !fifo_full;
  assign accept      = i_req_valid && o_req_ready;
  assign push        = accept && dec.hit && off_ok && id_ok;
  assign bad         = accept && !(dec.hit && off_ok && id_ok);

  // Entry handed to the queue for a request that decoded cleanly.
  always_comb begin
    push_entry       = '0;
    push_entry.hart  = dec.hart;
    push_entry.file  = dec.file;
    push_entry.ipnum = MsiIpnumW'(id_sel);
  end

  imsic_msi_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .i_clk   (i_clk),
    .ni_rst  (ni_rst),
    .i_push  (push),
    .i_data  (push_entry),
    .i_pop   (o_wr_valid && i_wr_ready),
    .o_data  (pop_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_wr_valid        = !fifo_empty;
  assign o_wr_hart         = pop_entry.hart[HartW-1:0];
  assign o_wr_file         = pop_entry.file[FileW-1:0];
  assign o_wr_ipnum        = pop_entry.ipnum[IpnumW-1:0];
  assign unused_entry_bits = ^pop_entry;

  // Drop pulse follows a rejected request by one cycle; the counter sticks at all-ones.
  always_comb begin
    drop_d     = bad;
    drop_cnt_d = drop_cnt_q;
    if (bad && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Drop accounting registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_drop     = drop_q;
  assign o_drop_cnt = drop_cnt_q;

endmodule

// File: doc/imsic_msi_decoder.md
Name: imsic_msi_decoder

Overview:
- Parametrised successor to the IMSIC register-map decoder. It accepts MSI write transactions from a simple valid/ready bus port and decodes machine and supervisor/guest interrupt-file pages for any hart and file count.
- Valid writes are queued in an internal FIFO. They are issued one per cycle, with backpressure, to the IMSIC interrupt-file bank as (hart, file, identity) triples.
- Sits between the AXI-lite protocol converter and the per-hart interrupt files.
- Adds behaviour the previous decoder lacks: SETEIPNUM_BE support, identity range checking, buffering, and drop accounting.

Parameters:
- NrHarts, 4, number of harts (≥1).
- NrInptFiles, 3, files per hart: 1 M-file plus NrInptFiles-1 S/VS files (≥2).
- NrSources, 64, interrupt identities per file; valid identities are 1..NrSources-1.
- AddrW, 32, request address width.
- MBase, 32'h2400_0000, base of the M-file window (4 KiB aligned).
- SBase, 32'h2800_0000, base of the S/VS-file window (4 KiB aligned).
- FifoDepth, 4, queue entries (power of two, ≥2).
- DropCntW, 16, width of the drop counter.

Ports:
- i_clk  in  1  clock
- ni_rst  in  1  reset; synchronous, active-low
- i_req_valid  in  1  write request valid
- o_req_ready  out  1  request accepted when valid&ready
- i_req_addr  in  AddrW  byte address
- i_req_data  in  32  write data
- o_wr_valid  out  1  decoded setipnum write valid
- i_wr_ready  in  1  file bank accepts the write
- o_wr_hart  out  $clog2(NrHarts) (min 1)  target hart
- o_wr_file  out  $clog2(NrInptFiles)  target file; 0 = M, ≥1 = S/VS
- o_wr_ipnum  out  $clog2(NrSources)  identity
- o_drop  out  1  one-cycle pulse per dropped request
- o_drop_cnt  out  DropCntW  saturating count of dropped requests

Behaviour:
- Reset (ni_rst low at a rising edge): FIFO emptied; o_wr_valid=0; o_wr_hart/file/ipnum=0; o_drop=0; o_drop_cnt=0. An in-flight request is discarded.
- o_req_ready = !fifo_full. This is combinational from registered state only; there is no pass-through when full.
- Handshake rules:
  - A request is accepted on a rising edge with i_req_valid&o_req_ready.
  - The pop side is AXI-style: o_wr_valid, once high, holds until i_wr_ready, and the payload is stable while held.
- Decode of an accepted request, in the same cycle:
  - M window: page p=(addr-MBase)>>12 with p<NrHarts. Result: hart=p, file=0.
  - S window: page p=(addr-SBase)>>12 with p<NrHarts*(NrInptFiles-1). Result: hart=p/(NrInptFiles-1), file=p%(NrInptFiles-1)+1. Division and modulo are by a constant.
  - Page offset addr[11:0]:
    - 12'h000: SETEIPNUM_LE; id=data.
    - 12'h004: SETEIPNUM_BE; id=byte-swapped data (see Optional Feature).
    - Anything else: dropped.
  - An identity is valid iff 1 ≤ id ≤ NrSources-1 using the full 32-bit value. Upper bits set means the request is dropped; there is no truncation.
- Valid decode: the entry is pushed at that edge, and o_wr_valid may assert the following cycle (1-cycle latency into an empty FIFO).
- Invalid decode (out of window, bad offset, bad id): the request is still accepted but not pushed. o_drop=1 for exactly the next cycle, and o_drop_cnt increments, saturating at all-ones.
- Simultaneous push and pop: both happen, and occupancy is unchanged.
- Pop at full raises ready in the next cycle, not the same cycle.
- Pointers are $clog2(FifoDepth) bits and wrap modulo FifoDepth. Full/empty is tracked with an extra occupancy-count bit.
- Ordering: writes issue strictly in acceptance order. No coalescing.

Optional Feature:
- Macro IMSIC_BE_SETIPNUM_EN.
- Defined: offset 12'h004 is decoded as SETEIPNUM_BE, with id = {data[7:0],data[15:8],data[23:16],data[31:24]}.
- Undefined: offset 12'h004 is treated as an invalid offset and dropped; no byte-swap logic is generated.

Decomposition:
- Shared package imsic_pkg gets:
  - msi_entry_t {hart, file, ipnum}
  - constants ImsicPageShift=12, SetipnumLeOff=12'h000, SetipnumBeOff=12'h004
  - function imsic_decode_page returning {hit, hart, file}
- Sub-module imsic_msi_fifo: a generic synchronous FIFO of msi_entry_t with full/empty and sync active-low reset. Decode, drop logic and the counter stay in the top level.

Test Plan:
- Reset: after reset, o_req_ready=1, o_wr_valid=0, o_drop_cnt=0.
- M-file write: NrHarts=4, NrInptFiles=3, write addr MBase+0x2000, data 5 → next cycle o_wr_valid=1, hart=2, file=0, ipnum=5.
- S/VS-file write: addr SBase+0x5000 (p=5) → hart=2, file=2; data 0x0000_0000 to any page → o_drop=1, o_drop_cnt=1, no o_wr_valid.
- Big-endian write, with IMSIC_BE_SETIPNUM_EN: addr MBase+0x004, data 32'h0700_0000 → ipnum=7. Without the macro: dropped, o_drop_cnt increments.
- Backpressure: hold i_wr_ready=0 and issue 5 valid writes → the 4th fills the FIFO and o_req_ready drops. Release ready → outputs come out in order and ready returns one cycle after the first pop.
- Saturation: DropCntW=2, issue 5 bad writes (id=64) → o_drop_cnt stays at 3.
- Mid-stream reset: assert ni_rst while the FIFO holds 2 entries → next cycle o_wr_valid=0 and the FIFO is empty.
